// File: rtl/mul_accumulator_pkg.sv
// Shared definitions for the multiply-accumulate readout block.
//   - opcode_e : operation applied to the running accumulator
//   - state_e  : handshake FSM state encoding
//   - K_DEFAULT: default multiplier operand width (accumulator is 2*K bits)
package mul_accumulator_pkg;

  localparam int K_DEFAULT = 16;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_ACC   = 2'b10,
    OP_CLEAR = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/mul_accumulator_if.sv
// Request/result bus between the multiplier result stage and the accumulator.
//   in_valid/in_ready : request handshake carrying opcode + product
//   out_valid/out_ready : result handshake carrying acc_out + overflow
// master = request producer / result consumer, slave = accumulator block.
interface mul_accumulator_if
  import mul_accumulator_pkg::*;
#(
  parameter int K = K_DEFAULT
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       opcode;
  logic [2*K-1:0]   product;
  logic             out_valid;
  logic             out_ready;
  logic [2*K-1:0]   acc_out;
  logic             overflow;

  modport master (
    output in_valid, opcode, product, out_ready,
    input  in_ready, out_valid, acc_out, overflow
  );

  modport slave (
    input  in_valid, opcode, product, out_ready,
    output in_ready, out_valid, acc_out, overflow
  );
endinterface

// File: rtl/mul_accumulator_acc_alu.sv
// Combinational next-state logic for the accumulator and sticky overflow.
//   acc_i/ovf_i   : current accumulator and overflow flag
//   product_i     : captured unsigned product
//   opcode_i      : captured operation
//   acc_o/ovf_o   : values to load when the operation executes
// SAT selects the overflow policy: 0 wraps, 1 clamps to all-ones.
module acc_alu
  import mul_accumulator_pkg::*;
#(
  parameter int K   = K_DEFAULT,
  parameter int SAT = 0
) (
  input  logic [2*K-1:0] acc_i,
  input  logic [2*K-1:0] product_i,
  input  opcode_e        opcode_i,
  input  logic           ovf_i,
  output logic [2*K-1:0] acc_o,
  output logic           ovf_o
);
  localparam int W = 2 * K;

  // One extra bit so the carry out of the unsigned add is visible.
  logic [W:0] sum;

  function automatic logic [W-1:0] sat_or_wrap(input logic [W:0] s);
    if (SAT != 0 && s[W]) return '1;
    return s[W-1:0];
  endfunction

  always_comb begin
    sum   = {1'b0, acc_i} + {1'b0, product_i};
    acc_o = acc_i;
    ovf_o = ovf_i;
    case (opcode_i)
      OP_LOAD: begin
        acc_o = product_i;
        ovf_o = 1'b0;
      end
      OP_ACC: begin
        acc_o = sat_or_wrap(sum);
        // Sticky: a carry sets the flag, a clean add leaves it alone.
        if (sum[W]) ovf_o = 1'b1;
      end
      OP_CLEAR: begin
        acc_o = '0;
        ovf_o = 1'b0;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mul_accumulator.sv
// Accumulator stage fed by the 16x16 multiplier.
// Captures {opcode, product} on the request handshake, applies the opcode
// to a running 2K-bit accumulator one cycle later, then holds the result
// with out_valid until the consumer takes it.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of mul_accumulator_if (request + result handshakes)
// acc_out and overflow mirror the accumulator registers at all times.
module mul_accumulator
  import mul_accumulator_pkg::*;
#(
  parameter int K   = K_DEFAULT,
  parameter int SAT = 0
) (
  input  logic                clk,
  input  logic                rst,
  mul_accumulator_if.slave    bus
);
  localparam int W = 2 * K;

  state_e         state_q;
  opcode_e        op_q;
  logic [W-1:0]   prod_q;
  logic [W-1:0]   acc_q;
  logic [W-1:0]   acc_d;
  logic           ovf_q;
  logic           ovf_d;
  logic           in_ready_q;
  logic           out_valid_q;

  acc_alu #(
    .K   (K),
    .SAT (SAT)
  ) u_acc_alu (
    .acc_i     (acc_q),
    .product_i (prod_q),
    .opcode_i  (op_q),
    .ovf_i     (ovf_q),
    .acc_o     (acc_d),
    .ovf_o     (ovf_d)
  );

  // in_ready/out_valid are registered alongside the state so they change
  // on the same edge as the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_NOP;
      prod_q      <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            prod_q     <= bus.product;
            op_q       <= opcode_e'(bus.opcode);
            in_ready_q <= 1'b0;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          acc_q       <= acc_d;
          ovf_q       <= ovf_d;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          // A request arriving together with out_ready waits for IDLE.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_out   = acc_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_mul_accumulator.sv
// Drives a wrapping (SAT=0) and a saturating (SAT=1) instance with identical
// stimulus; a reference model pushes expected results for both on every
// accepted request and they are popped when the result is presented.
module tb_mul_accumulator;
  import mul_accumulator_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  opcode = 2'b00;
  logic [31:0] product = '0;

  always #5 clk = ~clk;

  mul_accumulator_if #(.K(16)) if0 ();
  mul_accumulator_if #(.K(16)) if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.opcode    = opcode;
  assign if0.product   = product;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.opcode    = opcode;
  assign if1.product   = product;
  assign if1.out_ready = out_ready;

  mul_accumulator #(.K(16), .SAT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  mul_accumulator #(.K(16), .SAT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] acc0;
    logic        ovf0;
    logic [31:0] acc1;
    logic        ovf1;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_acc0, m_acc1;
  logic        m_ovf0, m_ovf1;

  function automatic void model_reset();
    m_acc0 = '0; m_acc1 = '0; m_ovf0 = 1'b0; m_ovf1 = 1'b0;
    sb.delete();
  endfunction

  function automatic void model_apply(input logic [1:0] op, input logic [31:0] p);
    logic [32:0] s0, s1;
    exp_t e;
    s0 = {1'b0, m_acc0} + {1'b0, p};
    s1 = {1'b0, m_acc1} + {1'b0, p};
    case (op)
      2'b01: begin m_acc0 = p; m_ovf0 = 1'b0; m_acc1 = p; m_ovf1 = 1'b0; end
      2'b10: begin
        m_acc0 = s0[31:0];
        if (s0[32]) m_ovf0 = 1'b1;
        if (s1[32]) begin m_acc1 = 32'hFFFF_FFFF; m_ovf1 = 1'b1; end
        else m_acc1 = s1[31:0];
      end
      2'b11: begin m_acc0 = '0; m_ovf0 = 1'b0; m_acc1 = '0; m_ovf1 = 1'b0; end
      default: ;
    endcase
    e.acc0 = m_acc0; e.ovf0 = m_ovf0; e.acc1 = m_acc1; e.ovf1 = m_ovf1;
    sb.push_back(e);
  endfunction

  // Issues one request with out_ready high and returns the result values as
  // seen on the cycle out_valid is up (the handshake edge follows).
  // lat counts falling edges from acceptance until out_valid is observed.
  task automatic do_op(input logic [1:0] op, input logic [31:0] p,
                       output logic [31:0] a0, output logic o0,
                       output logic [31:0] a1, output logic o1,
                       output int lat, output bit to);
    int n;
    to = 1'b0; lat = 0; a0 = '0; a1 = '0; o0 = 1'b0; o1 = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; opcode = op; product = p; out_ready = 1'b1;
    n = 0;
    while (!if0.in_ready && n < 20) begin @(negedge clk); n++; end
    if (!if0.in_ready) begin to = 1'b1; in_valid = 1'b0; return; end
    model_apply(op, p);
    @(negedge clk);
    in_valid = 1'b0; opcode = 2'($urandom); product = $urandom;
    lat = 1;
    while (!if0.out_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!if0.out_valid) begin to = 1'b1; return; end
    a0 = if0.acc_out; o0 = if0.overflow; a1 = if1.acc_out; o1 = if1.overflow;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    checks++; if (if0.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", if0.in_ready); end
    checks++; if (if0.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", if0.out_valid); end
    checks++; if (if0.acc_out !== 32'h0) begin failures++; $display("FAIL reset_acc0 got=%h exp=0", if0.acc_out); end
    checks++; if (if0.overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf0 got=%b exp=0", if0.overflow); end
    checks++; if (if1.acc_out !== 32'h0 || if1.in_ready !== 1'b1) begin failures++; $display("FAIL reset_dut1 acc=%h rdy=%b exp acc=0 rdy=1", if1.acc_out, if1.in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_load();
    logic [31:0] a0, a1; logic o0, o1; int lat; bit to; exp_t e;
    do_op(2'b01, 32'h0000_1234, a0, o0, a1, o1, lat, to);
    checks++; if (to !== 1'b0) begin failures++; $display("FAIL load_timeout got=%b exp=0", to); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL load_latency got=%0d exp=2", lat); end
    checks++; if (a0 !== 32'h0000_1234) begin failures++; $display("FAIL load_acc_const got=%h exp=00001234", a0); end
    if (sb.size() == 0) begin checks++; failures++; $display("FAIL load_sb empty queue"); end
    else begin
      e = sb.pop_front();
      checks++; if (a0 !== e.acc0 || o0 !== e.ovf0) begin failures++; $display("FAIL load_dut0 got=%h/%b exp=%h/%b", a0, o0, e.acc0, e.ovf0); end
      checks++; if (a1 !== e.acc1 || o1 !== e.ovf1) begin failures++; $display("FAIL load_dut1 got=%h/%b exp=%h/%b", a1, o1, e.acc1, e.ovf1); end
    end
    @(negedge clk);
    checks++; if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0) begin failures++; $display("FAIL load_t3_ready got rdy=%b vld=%b exp rdy=1 vld=0", if0.in_ready, if0.out_valid); end
  endtask

  task automatic test_overflow();
    logic [1:0]  ops[8]   = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b11, 2'b01, 2'b10, 2'b11};
    logic [31:0] prods[8] = '{32'hFFFE_0001, 32'hFFFE_0001, 32'h0, 32'hDEAD_BEEF,
                              32'h1234_5678, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] a0, a1; logic o0, o1; int lat; bit to; exp_t e;
    for (int i = 0; i < 8; i++) begin
      do_op(ops[i], prods[i], a0, o0, a1, o1, lat, to);
      if (to || sb.size() == 0) begin checks++; failures++; $display("FAIL ovf_step%0d timeout=%b queue=%0d", i, to, sb.size()); end
      else begin
        e = sb.pop_front();
        checks++; if (a0 !== e.acc0 || o0 !== e.ovf0) begin failures++; $display("FAIL ovf_step%0d_wrap got=%h/%b exp=%h/%b", i, a0, o0, e.acc0, e.ovf0); end
        checks++; if (a1 !== e.acc1 || o1 !== e.ovf1) begin failures++; $display("FAIL ovf_step%0d_sat got=%h/%b exp=%h/%b", i, a1, o1, e.acc1, e.ovf1); end
      end
      if (i == 1) begin
        checks++; if (a0 !== 32'hFFFC_0002 || a1 !== 32'hFFFF_FFFF || o0 !== 1'b1 || o1 !== 1'b1) begin
          failures++; $display("FAIL ovf_carry_const got=%h/%b %h/%b exp=fffc0002/1 ffffffff/1", a0, o0, a1, o1); end
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1; opcode = 2'b01; product = 32'h0000_ABCD; out_ready = 1'b0;
    checks++; if (if0.in_ready !== 1'b1) begin failures++; $display("FAIL hold_accept got=%b exp=1", if0.in_ready); end
    model_apply(2'b01, 32'h0000_ABCD);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (if0.out_valid !== 1'b1) begin failures++; $display("FAIL hold_enter got=%b exp=1", if0.out_valid); end
    e = sb[0];
    for (int k = 0; k < 5; k++) begin
      in_valid = ~in_valid; opcode = 2'b11; product = $urandom;
      @(negedge clk);
      checks++; if (if0.out_valid !== 1'b1 || if0.in_ready !== 1'b0) begin failures++; $display("FAIL hold_c%0d_hs got vld=%b rdy=%b exp vld=1 rdy=0", k, if0.out_valid, if0.in_ready); end
      checks++; if (if0.acc_out !== e.acc0 || if1.acc_out !== e.acc1) begin failures++; $display("FAIL hold_c%0d_acc got=%h %h exp=%h %h", k, if0.acc_out, if1.acc_out, e.acc0, e.acc1); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin failures++; $display("FAIL hold_release got vld=%b rdy=%b exp vld=0 rdy=1", if0.out_valid, if0.in_ready); end
    e = sb.pop_front();
    checks++; if (if0.acc_out !== e.acc0 || if0.overflow !== e.ovf0) begin failures++; $display("FAIL hold_no_capture got=%h/%b exp=%h/%b", if0.acc_out, if0.overflow, e.acc0, e.ovf0); end
  endtask

  task automatic test_back_to_back();
    int acc_n = 0, out_n = 0; exp_t e;
    @(negedge clk);
    in_valid = 1'b1; opcode = 2'b10; product = 32'h0000_0003; out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c == 12) in_valid = 1'b0;
      if (c < 12) begin
        checks++; if (if0.in_ready !== (c % 3 == 0)) begin failures++; $display("FAIL b2b_ready_c%0d got=%b exp=%b", c, if0.in_ready, (c % 3 == 0)); end
      end
      if (in_valid && if0.in_ready) begin model_apply(opcode, product); acc_n++; end
      if (if0.out_valid && out_ready) begin
        out_n++;
        if (sb.size() == 0) begin checks++; failures++; $display("FAIL b2b_sb unexpected result %h", if0.acc_out); end
        else begin
          e = sb.pop_front();
          checks++; if (if0.acc_out !== e.acc0 || if1.acc_out !== e.acc1) begin failures++; $display("FAIL b2b_result got=%h %h exp=%h %h", if0.acc_out, if1.acc_out, e.acc0, e.acc1); end
        end
      end
      @(negedge clk);
    end
    checks++; if (acc_n !== 4) begin failures++; $display("FAIL b2b_accepts got=%0d exp=4", acc_n); end
    checks++; if (out_n !== 4) begin failures++; $display("FAIL b2b_results got=%0d exp=4", out_n); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a0, a1; logic o0, o1; int lat; bit to; exp_t e; bit seen;
    do_op(2'b01, 32'h0000_0010, a0, o0, a1, o1, lat, to);
    if (to || sb.size() == 0) begin checks++; failures++; $display("FAIL rmid_load timeout=%b queue=%0d", to, sb.size()); end
    else begin
      e = sb.pop_front();
      checks++; if (a0 !== e.acc0 || a1 !== e.acc1) begin failures++; $display("FAIL rmid_load got=%h %h exp=%h %h", a0, a1, e.acc0, e.acc1); end
    end
    @(negedge clk);
    in_valid = 1'b1; opcode = 2'b10; product = 32'h0000_0005;
    checks++; if (if0.in_ready !== 1'b1) begin failures++; $display("FAIL rmid_accept got=%b exp=1", if0.in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (if0.in_ready !== 1'b0 || if0.out_valid !== 1'b0) begin failures++; $display("FAIL rmid_exec got rdy=%b vld=%b exp 0 0", if0.in_ready, if0.out_valid); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (if0.acc_out !== 32'h0 || if1.acc_out !== 32'h0) begin failures++; $display("FAIL rmid_acc got=%h %h exp=0", if0.acc_out, if1.acc_out); end
    checks++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1 || if0.overflow !== 1'b0) begin failures++; $display("FAIL rmid_ctrl got vld=%b rdy=%b ovf=%b exp 0 1 0", if0.out_valid, if0.in_ready, if0.overflow); end
    rst = 1'b0;
    model_reset();
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (if0.out_valid || if1.out_valid) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rmid_no_result got=%b exp=0", seen); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_load();
    test_overflow();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_accumulator.md
Name: mul_accumulator

Overview:
- Downstream consumer of the 16x16 behavioural multiplier.
- Registers each 32-bit product under a valid/ready handshake and applies a selected operation (load, accumulate, clear, nop) to a running accumulator.
- Presents the accumulator with output valid/ready and a sticky overflow flag.
- Sits between the multiplier's result bus and the display/readout stage of the datapath.

Parameters:
- K, 16, multiplier operand width; product and accumulator width is 2*K.
- SAT, 0, overflow policy: 0 = wrap modulo 2^(2K), 1 = saturate to all-ones.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  product and opcode are presented this cycle.
- in_ready  out  1  block can accept a new request this cycle.
- opcode  in  2  00 NOP, 01 LOAD, 10 ACC, 11 CLEAR.
- product  in  2K  multiplier result, unsigned.
- out_valid  out  1  acc_out and overflow hold a completed result.
- out_ready  in  1  consumer accepts the result.
- acc_out  out  2K  accumulator value.
- overflow  out  1  sticky overflow indicator.

Behaviour:
- Reset: synchronous only, checked on the rising clk edge, and dominates every other input. On reset:
  - state = IDLE, acc = 0, overflow = 0, captured registers = 0
  - in_ready = 1, out_valid = 0, acc_out = 0
- Reset asserted mid-operation (in EXEC or HOLD) aborts the operation. The pending result is discarded and never presented.
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid: capture product and opcode into registers, go to EXEC.
- EXEC (one cycle): in_ready = 0, out_valid = 0. Apply the captured opcode:
  - NOP: acc and overflow unchanged.
  - LOAD: acc = product, overflow = 0.
  - ACC: compute sum = acc + product at width 2K+1.
    - If carry = 1: overflow set to 1 (sticky); acc = sum[2K-1:0] when SAT = 0, or all-ones when SAT = 1.
    - Otherwise acc = sum[2K-1:0] and overflow is unchanged.
  - CLEAR: acc = 0, overflow = 0.
  - Then go to HOLD.
- HOLD:
  - out_valid = 1, in_ready = 0; acc_out and overflow are stable.
  - On out_ready = 1: go to IDLE.
  - Holding indefinitely while out_ready = 0 is legal.
- acc_out always reflects the acc register, including while out_valid = 0.
- Latency: request accepted at edge t; out_valid high from t+2; earliest next acceptance at t+3. Maximum throughput is one operation per 3 cycles.
- Inputs (product, opcode) are ignored whenever in_ready = 0; only the captured copies are used.
- out_ready is ignored outside HOLD.
- in_valid and out_ready both asserted in HOLD: the result is released; the new request is not taken until IDLE.
- Overflow clears only on LOAD, CLEAR or rst, never on NOP or on a non-carrying ACC.
- Accumulation is unsigned; no sign extension.

Decomposition:
- Shared package holds:
  - opcode constants OP_NOP = 2'b00, OP_LOAD = 2'b01, OP_ACC = 2'b10, OP_CLEAR = 2'b11
  - state encoding IDLE / EXEC / HOLD
  - default width K = 16
- One natural sub-module, acc_alu: combinational next-acc/next-overflow logic from (acc, product, opcode, SAT). It is kept separate so it can be unit-tested without the handshake.

Test Plan:
- Reset, then check → in_ready = 1, out_valid = 0, acc_out = 0, overflow = 0.
- LOAD with product 0x0000_1234, out_ready = 1 → out_valid at t+2, acc_out = 0x0000_1234, overflow = 0; in_ready back to 1 at t+3.
- LOAD 0xFFFE0001, then ACC 0xFFFE0001, SAT = 0 → acc_out = 0xFFFC0002, overflow = 1. Follow with NOP → overflow stays 1. Follow with CLEAR → acc_out = 0, overflow = 0.
- Same sequence with SAT = 1 → acc_out = 0xFFFFFFFF, overflow = 1.
- Hold out_ready = 0 for 5 cycles in HOLD while toggling in_valid and product → out_valid stays 1, acc_out stable, in_ready = 0, no new capture. Release out_ready → IDLE next cycle.
- Assert rst during EXEC after an ACC request with acc = 0x10 → next cycle acc_out = 0, out_valid never pulses for that request, in_ready = 1.
